// File: rtl/graph_poly_gen_if.sv
// Stream and result bus between the polynomial point generator and its consumer.
// The master side is the generator. The slave side is the plot/display stage or a bench.
interface graph_poly_gen_if #(
  parameter int WIDTH = 32,
  parameter int NPTS  = 64,
  parameter int IDXW  = $clog2(NPTS)
) ();

  logic                    start;
  logic [WIDTH-1:0]        x0;
  logic [WIDTH-1:0]        dx;
  logic [WIDTH-1:0]        a;
  logic [WIDTH-1:0]        b;
  logic [WIDTH-1:0]        c;

  logic                    pt_valid;
  logic                    pt_ready;
  logic [IDXW-1:0]         pt_idx;
  logic [WIDTH-1:0]        pt_x;
  logic [WIDTH-1:0]        pt_y;

  logic [NPTS*WIDTH-1:0]   xs;
  logic [NPTS*WIDTH-1:0]   ys;

  logic                    busy;
  logic                    complete;

  modport master (
    input  start, x0, dx, a, b, c, pt_ready,
    output pt_valid, pt_idx, pt_x, pt_y, xs, ys, busy, complete
  );

  modport slave (
    output start, x0, dx, a, b, c, pt_ready,
    input  pt_valid, pt_idx, pt_x, pt_y, xs, ys, busy, complete
  );

endinterface

// File: rtl/graph_poly_gen.sv
// Quadratic graph point generator.
// Produces y = a*x^2 + b*x + c for NPTS points x = x0 + k*dx by forward differencing.
// Multiplies happen only during the two init cycles. Each point then costs one add chain.
// All arithmetic wraps modulo 2^WIDTH, so the results equal the direct formula
// truncated to WIDTH bits.
module graph_poly_gen #(
  parameter int WIDTH = 32,
  parameter int NPTS  = 64,
  parameter int IDXW  = $clog2(NPTS)
) (
  input  logic              clk,
  input  logic              rst,
  graph_poly_gen_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT1,
    INIT2,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Coefficients captured on the accepted start.
  logic [WIDTH-1:0] x0_r;
  logic [WIDTH-1:0] dx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] c_r;

  // Products formed in INIT1: x0^2, x0*dx and dx^2.
  logic [WIDTH-1:0] p0_r;
  logic [WIDTH-1:0] p1_r;
  logic [WIDTH-1:0] p2_r;

  // Forward-difference state: current point, first difference, constant second difference.
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] d1_r;
  logic [WIDTH-1:0] d2_r;
  logic [IDXW-1:0]  k_r;

  logic [NPTS*WIDTH-1:0] xs_r;
  logic [NPTS*WIDTH-1:0] ys_r;

  logic start_ok;
  logic hs;
  logic last_pt;

  // A start is honoured only while nothing is in flight.
  // A handshake can only happen while a point is being presented.
  assign start_ok = bus.start && ((state == IDLE) || (state == DONE));
  assign hs       = (state == RUN) && bus.pt_ready;
  assign last_pt  = (k_r == IDXW'(NPTS - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: two fixed init cycles, then one point per handshake until the last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = INIT1;
      INIT1:   state_next = INIT2;
      INIT2:   state_next = RUN;
      RUN:     if (hs && last_pt) state_next = DONE;
      DONE:    if (start_ok) state_next = INIT1;
      default: state_next = IDLE;
    endcase
  end

  // Coefficient capture and the per-phase arithmetic that sets up and advances the differences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r <= '0;
      dx_r <= '0;
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= '0;
      p0_r <= '0;
      p1_r <= '0;
      p2_r <= '0;
      x_r  <= '0;
      y_r  <= '0;
      d1_r <= '0;
      d2_r <= '0;
      k_r  <= '0;
    end else begin
      if (start_ok) begin
        x0_r <= bus.x0;
        dx_r <= bus.dx;
        a_r  <= bus.a;
        b_r  <= bus.b;
        c_r  <= bus.c;
      end
      if (state == INIT1) begin
        p0_r <= x0_r * x0_r;
        p1_r <= x0_r * dx_r;
        p2_r <= dx_r * dx_r;
      end
      if (state == INIT2) begin
        x_r  <= x0_r;
        y_r  <= a_r * p0_r + b_r * x0_r + c_r;
        d1_r <= a_r * ((p1_r << 1) + p2_r) + b_r * dx_r;
        d2_r <= (a_r * p2_r) << 1;
        k_r  <= '0;
      end
      if (hs) begin
        x_r  <= x_r + dx_r;
        y_r  <= y_r + d1_r;
        d1_r <= d1_r + d2_r;
        k_r  <= k_r + IDXW'(1);
      end
    end
  end

  // Result buses: each accepted point lands in its own slot, and old slots persist until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_r <= '0;
      ys_r <= '0;
    end else if (hs) begin
      for (int i = 0; i < NPTS; i++) begin
        if (k_r == IDXW'(i)) begin
          xs_r[i*WIDTH +: WIDTH] <= x_r;
          ys_r[i*WIDTH +: WIDTH] <= y_r;
        end
      end
    end
  end

  assign bus.pt_valid = (state == RUN);
  assign bus.pt_idx   = k_r;
  assign bus.pt_x     = x_r;
  assign bus.pt_y     = y_r;
  assign bus.xs       = xs_r;
  assign bus.ys       = ys_r;
  assign bus.busy     = (state == INIT1) || (state == INIT2) || (state == RUN);
  assign bus.complete = (state == DONE);

endmodule

// File: tb/tb_graph_poly_gen.sv
// Directed bench for graph_poly_gen.
// Two instances are exercised: a 32-bit / 64-point one and an 8-bit / 20-point one
// that shows the modulo wrap.
module tb_graph_poly_gen;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // 10 ns clock.
  always #5 clk = ~clk;

  graph_poly_gen_if #(.WIDTH(32), .NPTS(64)) bus_a ();
  graph_poly_gen_if #(.WIDTH(8),  .NPTS(20)) bus_b ();

  graph_poly_gen #(.WIDTH(32), .NPTS(64)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  graph_poly_gen #(.WIDTH(8), .NPTS(20)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  // Direct evaluation of the polynomial modulo 2^32.
  function automatic logic [31:0] model_x(input logic [31:0] mx0, input logic [31:0] mdx, input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return mx0 + kk * mdx;
  endfunction

  function automatic logic [31:0] model_y(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [31:0] mc, input logic [31:0] mx);
    return ma * mx * mx + mb * mx + mc;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full run on instance A. ready_mode 1 stalls with a 1,0,0,1 pattern.
  // inject_at >= 0 pulses start with other coefficients at that cycle.
  // abort_at >= 0 fires rst while point abort_at is presented.
  task automatic apply_stimulus(input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] rc,
                                input logic [31:0] rx0, input logic [31:0] rdx,
                                input int ready_mode, input int inject_at, input int abort_at);
    int  cycles;
    int  k_exp;
    int  step;
    bit  hs;
    bit  aborted;
    bit  ready_pat [4];
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cycles  = 0;
    k_exp   = 0;
    step    = 0;
    aborted = 1'b0;

    bus_a.a        = ra;
    bus_a.b        = rb;
    bus_a.c        = rc;
    bus_a.x0       = rx0;
    bus_a.dx       = rdx;
    bus_a.pt_ready = 1'b1;
    bus_a.start    = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    check_output("init1_busy",     64'(bus_a.busy),     64'd1);
    check_output("init1_complete", 64'(bus_a.complete), 64'd0);
    check_output("init1_valid",    64'(bus_a.pt_valid), 64'd0);

    while (cycles < 400) begin
      if (bus_a.complete) break;
      if (cycles == 1) check_output("init2_valid", 64'(bus_a.pt_valid), 64'd0);
      if (cycles == 2) check_output("run_valid",   64'(bus_a.pt_valid), 64'd1);

      if (cycles == inject_at) begin
        bus_a.start = 1'b1;
        bus_a.a     = 32'd5;
        bus_a.b     = 32'd3;
        bus_a.c     = 32'd9;
        bus_a.x0    = 32'd100;
        bus_a.dx    = 32'd7;
      end else begin
        bus_a.start = 1'b0;
      end

      if ((abort_at >= 0) && bus_a.pt_valid && (k_exp == abort_at)) begin
        rst = 1'b1;
        #1;
        check_output("abort_valid",    64'(bus_a.pt_valid), 64'd0);
        check_output("abort_busy",     64'(bus_a.busy),     64'd0);
        check_output("abort_complete", 64'(bus_a.complete), 64'd0);
        check_output("abort_idx",      64'(bus_a.pt_idx),   64'd0);
        check_output("abort_xs_zero",  64'(|bus_a.xs),      64'd0);
        check_output("abort_ys_zero",  64'(|bus_a.ys),      64'd0);
        #1;
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end

      bus_a.pt_ready = (ready_mode == 1) ? ready_pat[step % 4] : 1'b1;
      step++;

      if (bus_a.pt_valid) begin
        check_output($sformatf("pt_idx@%0d", k_exp), 64'(bus_a.pt_idx), 64'(k_exp));
        check_output($sformatf("pt_x@%0d", k_exp),   64'(bus_a.pt_x),   64'(model_x(rx0, rdx, k_exp)));
        check_output($sformatf("pt_y@%0d", k_exp),   64'(bus_a.pt_y),
                     64'(model_y(ra, rb, rc, model_x(rx0, rdx, k_exp))));
      end
      hs = bus_a.pt_valid && bus_a.pt_ready;

      @(posedge clk);
      #1;
      cycles++;
      if (hs) k_exp++;
    end
    bus_a.start = 1'b0;

    if (aborted) begin
      @(posedge clk);
      #1;
    end else if (!bus_a.complete) begin
      check_output("run_timeout", 64'd1, 64'd0);
    end else begin
      check_output("handshakes_at_complete", 64'(k_exp), 64'd64);
      if (ready_mode == 0) check_output("edges_start_to_complete", 64'(cycles), 64'd66);
      for (int k = 0; k < 64; k++) begin
        check_output($sformatf("xs[%0d]", k), 64'(bus_a.xs[k*32 +: 32]), 64'(model_x(rx0, rdx, k)));
        check_output($sformatf("ys[%0d]", k), 64'(bus_a.ys[k*32 +: 32]),
                     64'(model_y(ra, rb, rc, model_x(rx0, rdx, k))));
      end
    end
  endtask

  // Main sequence.
  initial begin
    int n;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.pt_ready = 1'b0;
    bus_a.a = '0; bus_a.b = '0; bus_a.c = '0; bus_a.x0 = '0; bus_a.dx = '0;
    bus_b.start = 1'b0; bus_b.pt_ready = 1'b0;
    bus_b.a = '0; bus_b.b = '0; bus_b.c = '0; bus_b.x0 = '0; bus_b.dx = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid",    64'(bus_a.pt_valid), 64'd0);
    check_output("rst_busy",     64'(bus_a.busy),     64'd0);
    check_output("rst_complete", 64'(bus_a.complete), 64'd0);
    check_output("rst_idx",      64'(bus_a.pt_idx),   64'd0);
    check_output("rst_x",        64'(bus_a.pt_x),     64'd0);
    check_output("rst_y",        64'(bus_a.pt_y),     64'd0);
    check_output("rst_xs_zero",  64'(|bus_a.xs),      64'd0);
    check_output("rst_ys_zero",  64'(|bus_a.ys),      64'd0);
    check_output("rst_b_valid",  64'(bus_b.pt_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 8-bit wrap: y = x^2 mod 256.
    bus_b.a = 8'd1; bus_b.b = 8'd0; bus_b.c = 8'd0; bus_b.x0 = 8'd0; bus_b.dx = 8'd1;
    bus_b.pt_ready = 1'b1;
    bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    n = 0;
    while (!bus_b.complete && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("b_edges_start_to_complete", 64'(n), 64'd22);
    check_output("b_ys[2]",  64'(bus_b.ys[2*8 +: 8]),  64'd4);
    check_output("b_ys[15]", 64'(bus_b.ys[15*8 +: 8]), 64'd225);
    check_output("b_ys[16]", 64'(bus_b.ys[16*8 +: 8]), 64'd0);
    check_output("b_ys[17]", 64'(bus_b.ys[17*8 +: 8]), 64'd33);
    check_output("b_ys[19]", 64'(bus_b.ys[19*8 +: 8]), 64'd105);
    check_output("b_xs[19]", 64'(bus_b.xs[19*8 +: 8]), 64'd19);

    // y = x^2 over x = 0..63 with no backpressure.
    apply_stimulus(32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 0, -1, -1);
    check_output("run1_ys[63]", 64'(bus_a.ys[63*32 +: 32]), 64'd3969);
    check_output("run1_xs[63]", 64'(bus_a.xs[63*32 +: 32]), 64'd63);

    // y = 2x + 5 starting at x = -3.
    apply_stimulus(32'd0, 32'd2, 32'd5, -32'sd3, 32'd1, 0, -1, -1);
    check_output("run2_ys[0]",  64'(bus_a.ys[0*32 +: 32]),  64'hFFFF_FFFF);
    check_output("run2_ys[3]",  64'(bus_a.ys[3*32 +: 32]),  64'd5);
    check_output("run2_ys[10]", 64'(bus_a.ys[10*32 +: 32]), 64'd19);

    // y = x^2 again under a 1,0,0,1 ready pattern.
    apply_stimulus(32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 1, -1, -1);
    check_output("run3_ys[63]", 64'(bus_a.ys[63*32 +: 32]), 64'd3969);

    // A start pulse mid-run with other coefficients must not disturb the run.
    apply_stimulus(32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 0, 20, -1);

    // Restart from DONE with a constant polynomial.
    apply_stimulus(32'd0, 32'd0, 32'd7, 32'd0, 32'd1, 0, -1, -1);
    check_output("run5_ys[0]",  64'(bus_a.ys[0*32 +: 32]),  64'd7);
    check_output("run5_ys[63]", 64'(bus_a.ys[63*32 +: 32]), 64'd7);

    // Zero step: every point is 2*7^2 + 1 = 99.
    apply_stimulus(32'd2, 32'd0, 32'd1, 32'd7, 32'd0, 0, -1, -1);
    check_output("dx0_ys[40]", 64'(bus_a.ys[40*32 +: 32]), 64'd99);

    // Abort at k = 30, then a fresh full run.
    apply_stimulus(32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 0, -1, 30);
    apply_stimulus(32'd1, 32'd2, 32'd3, -32'sd5, 32'd2, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
